sodor_uop_model_multi: RTL
==========================

Name: sodor_uop_model_multi

Overview:
- Parametrised micro-update reference model of the Sodor 5-stage pipeline, used for lifting and equivalence checks against the RTL core.
- Walks one instruction through per-stage micro-state (DEC, EXE, MEM, WB, COMMIT) and exposes every stage-visible datum as a port.
- Generalises the single-I-type model: configurable XLEN and register count; I-type ALU, R-type ALU and conditional branches; a mode that returns to IDLE for back-to-back instructions.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64. SHAMT_W = $clog2(XLEN).
- NREGS, 32, architectural register count; power of 2, ≤32. RA_W = $clog2(NREGS).
- MULTI_INST, 0: 0 = done sticky after first commit; 1 = return to IDLE after commit.
- NOP_INST, 32'h00000013, encoding treated as pipeline-fill NOP.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- inst  in  32  fetched instruction (imem resp data)
- port_regfile  out  XLEN*NREGS  flat regfile; reg i at [XLEN*i +: XLEN]
- port_pc  out  XLEN  architectural pc
- port_state  out  3  micro-state encoding
- port_funct3  out  3  decoded funct3
- port_imm  out  XLEN  sign-extended immediate
- port_alu_out  out  XLEN  EXE result
- port_rs1_addr / port_rs2_addr  out  RA_W  read addresses
- port_rs1_data / port_rs2_data  out  XLEN  read data
- port_rd_addr  out  RA_W  writeback address
- port_rd_data  out  XLEN  writeback data
- port_start  out  1  instruction in flight
- port_done  out  1  commit complete
- port_illegal  out  1  one-cycle pulse: unsupported opcode seen in IDLE

Behaviour:
- Reset: regfile all 0, pc 0, state IDLE, start/done/illegal 0, all micro fields 0.
- States: IDLE=0, DEC=1, EXE=2, MEM=3, WB=4, COMMIT=5, DONE=6. All transitions occur on a clk edge.
- IDLE, no reset, done=0:
  - inst==NOP_INST: pc += 4; stay IDLE.
  - opcode 0010011 (I), 0110011 (R) or 1100011 (B): go to DEC, start=1. On the same edge latch rs1/rs2 addr, funct3, funct7, opcode, imm (I: inst[31:20]; B: b-imm with bit0=0; R: 0), rs1/rs2 data from regfile, and the instruction pc. alu_out, rd_addr, rd_data = 0.
  - any other opcode: illegal=1 for one cycle; pc held; stay IDLE.
- DEC→EXE:
  - I: alu_out = ALU(rs1_data, imm).
  - R: alu_out = ALU(rs1_data, rs2_data, funct7).
  - B: alu_out = taken ? 1 : 0.
  - Zero rs1/rs2 addr/data and imm.
- EXE→MEM: stage result held internally; all visible micro fields zeroed.
- MEM→WB: rd_data = stage result; rd_addr = inst rd. For B, both forced to 0.
- WB→COMMIT:
  - I/R with rd≠0: regfile[rd] = rd_data. rd=0 leaves x0 at 0.
  - pc = B taken ? inst_pc + imm : inst_pc + 4.
  - Zero rd fields.
- COMMIT→ MULTI_INST=0: DONE, done=1, start=0; held until reset, inst ignored.
- COMMIT→ MULTI_INST=1: IDLE, done pulses 1 for one cycle, start=0.
- ALU:
  - funct3 0: add, or sub when R and funct7=0100000.
  - 1: sll. 2: slt (signed). 3: sltu.
  - 4: xor. 5: srl, or true arithmetic sra when funct7/imm[11:5]=0100000. 6: or. 7: and.
  - Shift amount = low SHAMT_W bits. All arithmetic is modulo 2^XLEN.
- Branch funct3: 0 beq, 1 bne, 4 blt, 5 bge, 6 bltu, 7 bgeu. funct3 2/3 → not taken.
- Register addresses are truncated to RA_W bits.
- Reset mid-operation has priority over every state and aborts with no architectural update.

Decomposition:
- Shared package sodor_uop_pkg: opcode constants, state encoding, NOP_INST, decode functions (get_rs1/rs2/rd/funct3/funct7, i/b imm), alu_compute and branch_taken functions.
- One sub-module, sodor_uop_alu: combinational, parametrised on XLEN; shared with the branch comparator.

Test Plan:
- Reset, then 3 NOPs → pc 0→12, state IDLE, start 0.
- MULTI_INST=0: addi x1,x0,5 (0x00500093) → start on edge 1, x1=5 and pc=4 on commit edge 5, done=1 sticky, later inst ignored.
- MULTI_INST=1: addi x1,x0,-8 (0xFF800093), then srai x5,x1,1 (0x4010D293) → x5=0xFFFFFFFC. Then sub x3,x5,x1 (0x401281B3) → x3=4.
- beq x0,x0,+8 (0x00000463) at pc=4 → pc=12, regfile unchanged, rd_addr 0. bne x0,x0,+8 → pc=8.
- addi x0,x0,7 (0x00700013) → x0 stays 0, pc+4. Opcode 0x0000007F → illegal pulse, pc held.
- Assert reset in EXE → next cycle all outputs at reset values, no regfile write.

Source files
------------

// File: rtl/sodor_uop_pkg.sv
// Shared decode, ALU and branch helpers for the Sodor micro-update model.
package sodor_uop_pkg;

  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_B   = 7'b1100011;
  localparam logic [6:0] F7_ALT = 7'b0100000;

  localparam logic [31:0] NOP_ENC = 32'h00000013;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_DEC    = 3'd1;
  localparam logic [2:0] S_EXE    = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_COMMIT = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;

  function automatic logic [6:0] get_opcode(input logic [31:0] i);
    return i[6:0];
  endfunction

  function automatic logic [4:0] get_rd(input logic [31:0] i);
    return i[11:7];
  endfunction

  function automatic logic [2:0] get_funct3(input logic [31:0] i);
    return i[14:12];
  endfunction

  function automatic logic [4:0] get_rs1(input logic [31:0] i);
    return i[19:15];
  endfunction

  function automatic logic [4:0] get_rs2(input logic [31:0] i);
    return i[24:20];
  endfunction

  function automatic logic [6:0] get_funct7(input logic [31:0] i);
    return i[31:25];
  endfunction

  function automatic logic [31:0] get_i_imm(input logic [31:0] i);
    return {{20{i[31]}}, i[31:20]};
  endfunction

  function automatic logic [31:0] get_b_imm(input logic [31:0] i);
    return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
  endfunction

  // Operands arrive sign-extended to 64 bits; only srl needs the raw width.
  function automatic logic [63:0] alu_compute(
    input logic [63:0] a,
    input logic [63:0] b,
    input logic [5:0]  sh,
    input logic [2:0]  f3,
    input logic        alt,
    input logic        is64
  );
    logic [63:0] au;
    logic [63:0] r;
    au = is64 ? a : {32'b0, a[31:0]};
    r  = '0;
    case (f3)
      3'd0: r = alt ? a - b : a + b;
      3'd1: r = a << sh;
      3'd2: r = {63'b0, ($signed(a) < $signed(b))};
      3'd3: r = {63'b0, (a < b)};
      3'd4: r = a ^ b;
      3'd5: begin
        if (alt) r = $signed(a) >>> sh;
        else     r = au >> sh;
      end
      3'd6: r = a | b;
      default: r = a & b;
    endcase
    return r;
  endfunction

  function automatic logic branch_taken(
    input logic [63:0] a,
    input logic [63:0] b,
    input logic [2:0]  f3
  );
    logic t;
    t = 1'b0;
    case (f3)
      3'd0: t = (a == b);
      3'd1: t = (a != b);
      3'd4: t = ($signed(a) < $signed(b));
      3'd5: t = ($signed(a) >= $signed(b));
      3'd6: t = (a < b);
      3'd7: t = (a >= b);
      default: t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/sodor_uop_model_multi_if.sv
// Instruction input and stage-visible observation bundle of the model.
interface sodor_uop_model_multi_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
);
  localparam int RA_W = $clog2(NREGS);

  logic [31:0]           inst;
  logic [XLEN*NREGS-1:0] port_regfile;
  logic [XLEN-1:0]       port_pc;
  logic [2:0]            port_state;
  logic [2:0]            port_funct3;
  logic [XLEN-1:0]       port_imm;
  logic [XLEN-1:0]       port_alu_out;
  logic [RA_W-1:0]       port_rs1_addr;
  logic [RA_W-1:0]       port_rs2_addr;
  logic [XLEN-1:0]       port_rs1_data;
  logic [XLEN-1:0]       port_rs2_data;
  logic [RA_W-1:0]       port_rd_addr;
  logic [XLEN-1:0]       port_rd_data;
  logic                  port_start;
  logic                  port_done;
  logic                  port_illegal;

  modport master (
    input  inst,
    output port_regfile, port_pc, port_state, port_funct3,
    output port_imm, port_alu_out,
    output port_rs1_addr, port_rs2_addr,
    output port_rs1_data, port_rs2_data,
    output port_rd_addr, port_rd_data,
    output port_start, port_done, port_illegal
  );

  modport slave (
    output inst,
    input  port_regfile, port_pc, port_state, port_funct3,
    input  port_imm, port_alu_out,
    input  port_rs1_addr, port_rs2_addr,
    input  port_rs1_data, port_rs2_data,
    input  port_rd_addr, port_rd_data,
    input  port_start, port_done, port_illegal
  );

endinterface

// File: rtl/sodor_uop_alu.sv
// Combinational ALU plus branch comparator on the same operands.
module sodor_uop_alu
  import sodor_uop_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [2:0]      funct3,
  input  logic            alt,
  output logic [XLEN-1:0] y,
  output logic            taken
);
  localparam int SHAMT_W = $clog2(XLEN);
  localparam logic IS64 = (XLEN == 64);

  logic [63:0] a64;
  logic [63:0] b64;
  logic [5:0]  sh;

  assign a64 = 64'($signed(a));
  assign b64 = 64'($signed(b));
  assign sh  = 6'(b[SHAMT_W-1:0]);

  assign y     = XLEN'(alu_compute(a64, b64, sh, funct3, alt, IS64));
  assign taken = branch_taken(a64, b64, funct3);

endmodule

// File: rtl/sodor_uop_model_multi.sv
// Per-stage micro-update model of one Sodor instruction (I, R, B types).
module sodor_uop_model_multi
  import sodor_uop_pkg::*;
#(
  parameter int          XLEN       = 32,
  parameter int          NREGS      = 32,
  parameter bit          MULTI_INST = 1'b0,
  parameter logic [31:0] NOP_INST   = NOP_ENC
) (
  input logic                    clk,
  input logic                    reset,
  sodor_uop_model_multi_if.master bus
);
  localparam int RA_W = $clog2(NREGS);

  logic [XLEN-1:0] rf [NREGS];
  logic [2:0]      state;
  logic [XLEN-1:0] pc, inst_pc, tgt, res;
  logic [XLEN-1:0] imm, alu_out, rs1_data, rs2_data, rd_data;
  logic [RA_W-1:0] rs1_addr, rs2_addr, rd_addr, rd_lat;
  logic [2:0]      funct3;
  logic [6:0]      funct7, opcode;
  logic            start, done, illegal, taken;

  logic [6:0]      d_op;
  logic [RA_W-1:0] d_rs1, d_rs2;
  logic [XLEN-1:0] d_imm;
  logic            d_legal;

  assign d_op    = get_opcode(bus.inst);
  assign d_rs1   = RA_W'(get_rs1(bus.inst));
  assign d_rs2   = RA_W'(get_rs2(bus.inst));
  assign d_legal = (d_op == OP_I) || (d_op == OP_R) || (d_op == OP_B);

  always_comb begin
    d_imm = '0;
    unique case (1'b1)
      d_op == OP_I: d_imm = XLEN'($signed(get_i_imm(bus.inst)));
      d_op == OP_B: d_imm = XLEN'($signed(get_b_imm(bus.inst)));
      default:      d_imm = '0;
    endcase
  end

  logic [XLEN-1:0] alu_b, alu_y;
  logic            alt, alu_tk;

  assign alu_b = (opcode == OP_I) ? imm : rs2_data;
  assign alt   = (funct3 == 3'd0)
               ? (opcode == OP_R && funct7 == F7_ALT)
               : (funct7 == F7_ALT);

  sodor_uop_alu #(.XLEN(XLEN)) u_alu (
    .a      (rs1_data),
    .b      (alu_b),
    .funct3 (funct3),
    .alt    (alt),
    .y      (alu_y),
    .taken  (alu_tk)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
      state    <= S_IDLE;
      pc       <= '0;
      inst_pc  <= '0;
      tgt      <= '0;
      res      <= '0;
      imm      <= '0;
      alu_out  <= '0;
      rs1_data <= '0;
      rs2_data <= '0;
      rd_data  <= '0;
      rs1_addr <= '0;
      rs2_addr <= '0;
      rd_addr  <= '0;
      rd_lat   <= '0;
      funct3   <= '0;
      funct7   <= '0;
      opcode   <= '0;
      start    <= 1'b0;
      done     <= 1'b0;
      illegal  <= 1'b0;
      taken    <= 1'b0;
    end else begin
      illegal <= 1'b0;
      case (state)
        S_IDLE: begin
          if (done) begin
            done <= 1'b0;
          end else if (bus.inst == NOP_INST) begin
            pc <= pc + XLEN'(4);
          end else if (d_legal) begin
            state    <= S_DEC;
            start    <= 1'b1;
            opcode   <= d_op;
            funct3   <= get_funct3(bus.inst);
            funct7   <= get_funct7(bus.inst);
            rs1_addr <= d_rs1;
            rs2_addr <= d_rs2;
            rd_lat   <= RA_W'(get_rd(bus.inst));
            imm      <= d_imm;
            rs1_data <= rf[d_rs1];
            rs2_data <= rf[d_rs2];
            inst_pc  <= pc;
            alu_out  <= '0;
            rd_addr  <= '0;
            rd_data  <= '0;
          end else begin
            illegal <= 1'b1;
          end
        end
        S_DEC: begin
          state    <= S_EXE;
          alu_out  <= (opcode == OP_B) ? XLEN'(alu_tk) : alu_y;
          res      <= (opcode == OP_B) ? XLEN'(alu_tk) : alu_y;
          taken    <= (opcode == OP_B) && alu_tk;
          tgt      <= inst_pc + imm;
          rs1_addr <= '0;
          rs2_addr <= '0;
          rs1_data <= '0;
          rs2_data <= '0;
          imm      <= '0;
        end
        S_EXE: begin
          state   <= S_MEM;
          alu_out <= '0;
          funct3  <= '0;
        end
        S_MEM: begin
          state <= S_WB;
          if (opcode == OP_B) begin
            rd_data <= '0;
            rd_addr <= '0;
          end else begin
            rd_data <= res;
            rd_addr <= rd_lat;
          end
        end
        S_WB: begin
          state <= S_COMMIT;
          if (opcode != OP_B && rd_addr != '0) rf[rd_addr] <= rd_data;
          pc      <= taken ? tgt : inst_pc + XLEN'(4);
          rd_addr <= '0;
          rd_data <= '0;
        end
        S_COMMIT: begin
          state <= MULTI_INST ? S_IDLE : S_DONE;
          start <= 1'b0;
          done  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  for (genvar g = 0; g < NREGS; g++) begin : g_rf
    assign bus.port_regfile[XLEN*g +: XLEN] = rf[g];
  end

  assign bus.port_pc       = pc;
  assign bus.port_state    = state;
  assign bus.port_funct3   = funct3;
  assign bus.port_imm      = imm;
  assign bus.port_alu_out  = alu_out;
  assign bus.port_rs1_addr = rs1_addr;
  assign bus.port_rs2_addr = rs2_addr;
  assign bus.port_rs1_data = rs1_data;
  assign bus.port_rs2_data = rs2_data;
  assign bus.port_rd_addr  = rd_addr;
  assign bus.port_rd_data  = rd_data;
  assign bus.port_start    = start;
  assign bus.port_done     = done;
  assign bus.port_illegal  = illegal;

endmodule
